// File: rtl/cmp_share_sched_pkg.sv
// cmp_share_sched_pkg
//   Shared definitions for the comparator-sharing scheduler. It holds the
//   FSM state encoding and the round-robin next-pointer helper.
package cmp_share_sched_pkg;

  // Each granted operation walks all four states in order.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP_AB = 2'd1,
    CMP_BA = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Round-robin successor of a requester index, wrapping n-1 back to 0.
  // The calculation uses int, so non-power-of-two requester counts also wrap correctly.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/cmp_share_sched_gtcmp.sv
// cmp_share_sched_gtcmp
//   Purely combinational W-bit unsigned greater-than comparator. This is the
//   single magnitude resource that the scheduler time-shares.
// Ports:
//   a, b : unsigned operands
//   gt   : 1 when a > b
module cmp_share_sched_gtcmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/cmp_share_sched.sv
// cmp_share_sched
//   Round-robin scheduler that shares one greater-than comparator among N
//   requesters. A granted request makes two passes through the comparator:
//   first A>B, then B>A. The results are latched as greater/less/equal flags,
//   and a done pulse is sent to the owning requester.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_i      : per-requester level request
//   data_a_i   : packed operand A, requester k at [k*W +: W]
//   data_b_i   : packed operand B, requester k at [k*W +: W]
//   gnt_o      : one-hot grant pulse (operands already latched)
//   done_o     : one-hot result-valid pulse
//   gthan_o    : latched A>B
//   lthan_o    : latched A<B
//   eq_o       : latched A==B
//   res_id_o   : owner of the current result
//   busy_o     : high whenever an operation is in flight
module cmp_share_sched
  import cmp_share_sched_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] data_a_i,
  input  logic [N*W-1:0] data_b_i,
  output logic [N-1:0]   gnt_o,
  output logic [N-1:0]   done_o,
  output logic           gthan_o,
  output logic           lthan_o,
  output logic           eq_o,
  output logic [IDW-1:0] res_id_o,
  output logic           busy_o
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] pick_id;
  logic           pick_vld;
  logic [W-1:0]   op_a, op_b;
  logic [W-1:0]   cmp_x, cmp_y;
  logic           cmp_swap;
  logic           cmp_gt;
  logic           gt_r, lt_r;
  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];

  // Unpack the flat operand buses so each requester can be selected by its index.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_arr[k] = data_a_i[k*W +: W];
      b_arr[k] = data_b_i[k*W +: W];
    end
  end

  // Round-robin pick: the scan starts at rr_ptr, and the first asserted request wins.
  always_comb begin
    int             sum;
    logic [IDW-1:0] cand;
    sum      = 0;
    cand     = '0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(rr_ptr) + i;
      if (sum >= N) sum = sum - N;
      cand = IDW'(sum);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: IDLE waits for a request, then the three operation states run in sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CMP_AB;
      CMP_AB:  state_nxt = CMP_BA;
      CMP_BA:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant and done pulses go to cur_id. During CMP_BA the comparator inputs are swapped.
  always_comb begin
    gnt_o    = '0;
    done_o   = '0;
    busy_o   = (state != IDLE);
    cmp_swap = (state == CMP_BA);
    if (state == CMP_AB) gnt_o[cur_id]  = 1'b1;
    if (state == DONE)   done_o[cur_id] = 1'b1;
  end

  assign cmp_x = cmp_swap ? op_b : op_a;
  assign cmp_y = cmp_swap ? op_a : op_b;

  cmp_share_sched_gtcmp #(.W(W)) u_gtcmp (
    .a  (cmp_x),
    .b  (cmp_y),
    .gt (cmp_gt)
  );

  // Datapath registers. The operands are latched when the request is picked, so later
  // changes on the data inputs cannot disturb the operation. The result flags are loaded at
  // the end of CMP_BA, so they are valid during DONE and hold until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cur_id   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      gt_r     <= 1'b0;
      lt_r     <= 1'b0;
      gthan_o  <= 1'b0;
      eq_o     <= 1'b0;
      res_id_o <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        op_a   <= a_arr[pick_id];
        op_b   <= b_arr[pick_id];
        cur_id <= pick_id;
      end
      if (state == CMP_AB) begin
        gt_r   <= cmp_gt;
        rr_ptr <= IDW'(rr_next(int'(cur_id), N));
      end
      if (state == CMP_BA) begin
        lt_r     <= cmp_gt;
        gthan_o  <= gt_r;
        eq_o     <= ~gt_r & ~cmp_gt;
        res_id_o <= cur_id;
      end
    end
  end

  assign lthan_o = lt_r;

endmodule

// File: tb/tb_cmp_share_sched.sv
// tb_cmp_share_sched
//   Directed bench for cmp_share_sched. When an operation is launched, its expected
//   result is pushed onto a scoreboard queue. The entry is popped and compared
//   when done_o fires.
module tb_cmp_share_sched;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_a_i;
  logic [N*W-1:0] data_b_i;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic           gthan_o;
  logic           lthan_o;
  logic           eq_o;
  logic [IDW-1:0] res_id_o;
  logic           busy_o;

  typedef struct {
    logic [N-1:0]   done;
    logic [IDW-1:0] id;
    logic           gt;
    logic           lt;
    logic           eq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  cmp_share_sched #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .data_a_i (data_a_i),
    .data_b_i (data_b_i),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .gthan_o  (gthan_o),
    .lthan_o  (lthan_o),
    .eq_o     (eq_o),
    .res_id_o (res_id_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req);
    req_i = req;
  endtask

  task automatic setOperand(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    data_a_i[k*W +: W] = a;
    data_b_i[k*W +: W] = b;
  endtask

  // Reference result for one unsigned comparison.
  task automatic pushExp(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.done    = '0;
    e.done[k] = 1'b1;
    e.id      = IDW'(k);
    e.gt      = (a > b);
    e.lt      = (a < b);
    e.eq      = (a == b);
    exp_q.push_back(e);
  endtask

  task automatic waitGnt(input logic [N-1:0] exp_gnt, input string tag);
    int n = 0;
    while (gnt_o == '0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_gnt"}, 64'(gnt_o), 64'(exp_gnt));
  endtask

  task automatic waitDone(input string tag, input int exp_lat);
    int   n = 0;
    exp_t e;
    while (done_o == '0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_lat"}, 64'(n), 64'(exp_lat));
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_done"},  64'(done_o),   64'(e.done));
      checkOutput({tag, "_gt"},    64'(gthan_o),  64'(e.gt));
      checkOutput({tag, "_lt"},    64'(lthan_o),  64'(e.lt));
      checkOutput({tag, "_eq"},    64'(eq_o),     64'(e.eq));
      checkOutput({tag, "_resid"}, 64'(res_id_o), 64'(e.id));
    end
  endtask

  initial begin
    int last_done;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst      = 1'b1;
    req_i    = '0;
    data_a_i = '0;
    data_b_i = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_gnt",   64'(gnt_o),    64'(0));
    checkOutput("rst_done",  64'(done_o),   64'(0));
    checkOutput("rst_gt",    64'(gthan_o),  64'(0));
    checkOutput("rst_lt",    64'(lthan_o),  64'(0));
    checkOutput("rst_eq",    64'(eq_o),     64'(0));
    checkOutput("rst_resid", 64'(res_id_o), 64'(0));
    checkOutput("rst_busy",  64'(busy_o),   64'(0));

    // A: single request, explicit cycle-by-cycle timing
    setOperand(0, 32'd5, 32'd3);
    pushExp(0, 32'd5, 32'd3);
    applyStimulus(4'b0001);
    tick();
    checkOutput("A_gnt_t1",  64'(gnt_o),  64'(4'b0001));
    checkOutput("A_busy_t1", 64'(busy_o), 64'(1));
    applyStimulus(4'b0000);
    tick();
    checkOutput("A_gnt_t2",  64'(gnt_o),  64'(0));
    checkOutput("A_done_t2", 64'(done_o), 64'(0));
    checkOutput("A_busy_t2", 64'(busy_o), 64'(1));
    tick();
    waitDone("A", 0);
    checkOutput("A_busy_t3", 64'(busy_o), 64'(1));
    tick();
    checkOutput("A_busy_t4", 64'(busy_o),  64'(0));
    checkOutput("A_done_t4", 64'(done_o),  64'(0));
    checkOutput("A_hold_gt", 64'(gthan_o), 64'(1));

    // B: a request that arrives while busy is not granted until IDLE
    setOperand(0, 32'd10, 32'd20);
    pushExp(0, 32'd10, 32'd20);
    applyStimulus(4'b0001);
    waitGnt(4'b0001, "B0");
    setOperand(1, 32'd8, 32'd8);
    pushExp(1, 32'd8, 32'd8);
    applyStimulus(4'b0010);
    tick();
    checkOutput("B_gnt_ba", 64'(gnt_o), 64'(0));
    tick();
    checkOutput("B_gnt_dn", 64'(gnt_o), 64'(0));
    waitDone("B0", 0);
    tick();
    checkOutput("B_gnt_idle",  64'(gnt_o),  64'(0));
    checkOutput("B_busy_idle", 64'(busy_o), 64'(0));
    tick();
    checkOutput("B1_gnt", 64'(gnt_o), 64'(4'b0010));
    applyStimulus(4'b0000);
    waitDone("B1", 2);

    // C: equal operands at full scale
    tick();
    setOperand(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pushExp(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(4'b0100);
    waitGnt(4'b0100, "C");
    applyStimulus(4'b0000);
    waitDone("C", 2);

    // D: reset during CMP_BA abandons the operation and clears rr_ptr
    tick();
    setOperand(0, 32'd1, 32'd2);
    applyStimulus(4'b0001);
    waitGnt(4'b0001, "D");
    applyStimulus(4'b0000);
    tick();
    checkOutput("D_busy_ba", 64'(busy_o), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("D_done",  64'(done_o),   64'(0));
    checkOutput("D_gnt",   64'(gnt_o),    64'(0));
    checkOutput("D_gt",    64'(gthan_o),  64'(0));
    checkOutput("D_lt",    64'(lthan_o),  64'(0));
    checkOutput("D_eq",    64'(eq_o),     64'(0));
    checkOutput("D_resid", 64'(res_id_o), 64'(0));
    checkOutput("D_busy",  64'(busy_o),   64'(0));
    tick();
    checkOutput("D_done2", 64'(done_o), 64'(0));

    // E: after reset, requester 0 is granted first. Requester 1 then changes A after its grant
    setOperand(0, 32'd7, 32'd7);
    setOperand(1, 32'd1, 32'd4);
    pushExp(0, 32'd7, 32'd7);
    pushExp(1, 32'd1, 32'd4);
    applyStimulus(4'b0011);
    waitGnt(4'b0001, "E0");
    applyStimulus(4'b0010);
    waitDone("E0", 2);
    waitGnt(4'b0010, "E1");
    setOperand(1, 32'd9, 32'd4);
    applyStimulus(4'b0000);
    waitDone("E1", 2);

    // F: all requesters held, so round-robin order wraps and done pulses are 4 cycles apart
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) setOperand(k, W'(k), 32'd2);
    for (int g = 0; g < 5; g++) pushExp(order[g], W'(order[g]), 32'd2);
    applyStimulus(4'b1111);
    last_done = 0;
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      oh           = '0;
      oh[order[g]] = 1'b1;
      waitGnt(oh, $sformatf("F%0d", g));
      if (g == 4) applyStimulus(4'b0000);
      waitDone($sformatf("F%0d", g), 2);
      if (g > 0) checkOutput($sformatf("F%0d_spacing", g), 64'(cyc - last_done), 64'(4));
      last_done = cyc;
    end
    applyStimulus(4'b0000);
    tick();
    tick();
    checkOutput("F_busy_end", 64'(busy_o),        64'(0));
    checkOutput("F_sb_left",  64'(exp_q.size()),  64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
